// File: rtl/hermes_pkg.sv
// Shared Hermes router types: port indices, tracker phases, control FSM
// states and the XY routing function.
package hermes_pkg;

    localparam int NPORT = 5;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        PH_HEADER  = 2'd0,
        PH_SIZE    = 2'd1,
        PH_PAYLOAD = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    // X is resolved before Y; coordinates compare as unsigned bytes.
    function automatic port_e xy_route(
        input logic [15:0] here,
        input logic [15:0] target
    );
        port_e dir;
        if (target[15:8] > here[15:8])      dir = EAST;
        else if (target[15:8] < here[15:8]) dir = WEST;
        else if (target[7:0] > here[7:0])   dir = NORTH;
        else if (target[7:0] < here[7:0])   dir = SOUTH;
        else                                dir = LOCAL;
        return dir;
    endfunction

endpackage

// File: rtl/hermes_rr_arbiter.sv
// Five-input request arbiter. With HERMES_RR_ARBITER_EN it is round-robin;
// otherwise fixed priority LOCAL > EAST > WEST > NORTH > SOUTH.
module hermes_rr_arbiter
    import hermes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] req_i,
    input  logic       advance_i,
    output logic [2:0] grant_o,
    output logic       valid_o
);

`ifdef HERMES_RR_ARBITER_EN
    logic [2:0] ptr_q;
    logic [3:0] idx;

    // Search starts one past the last winner, wrapping modulo NPORT.
    always_comb begin
        grant_o = 3'd0;
        valid_o = 1'b0;
        idx     = 4'd0;
        for (int i = 1; i <= NPORT; i++) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'(NPORT)) idx = idx - 4'(NPORT);
            if (!valid_o && req_i[idx[2:0]]) begin
                valid_o = 1'b1;
                grant_o = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= LOCAL;
        end else if (advance_i && valid_o) begin
            ptr_q <= grant_o;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = clk_i ^ rst_i ^ advance_i;

    always_comb begin
        valid_o = |req_i;
        if (req_i[LOCAL])      grant_o = LOCAL;
        else if (req_i[EAST])  grant_o = EAST;
        else if (req_i[WEST])  grant_o = WEST;
        else if (req_i[NORTH]) grant_o = NORTH;
        else if (req_i[SOUTH]) grant_o = SOUTH;
        else                   grant_o = 3'd0;
    end
`endif

endmodule

// File: rtl/hermes_switch_control.sv
// Hermes switch control: arbitration, XY routing and per-input packet
// tracking. Define HERMES_RR_ARBITER_EN for round-robin arbitration.
module hermes_switch_control
    import hermes_pkg::*;
#(
    parameter int FLIT_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [15:0]            address_i,
    input  logic [4:0]             req_i,
    input  logic [5*FLIT_SIZE-1:0] flit_i,
    input  logic [4:0]             data_av_i,
    input  logic [4:0]             credit_i,
    output logic [4:0]             req_ack_o,
    output logic [4:0]             data_ack_o,
    output logic [14:0]            in_sel_o,
    output logic [4:0]             out_busy_o
);

    state_e               state_q;
    logic [2:0]           sel_q;
    port_e                out_q;
    port_e                route_out;
    logic [2:0]           arb_grant;
    logic                 arb_valid;
    logic [4:0]           conn_valid_q;
    logic [2:0]           conn_q  [NPORT];
    phase_e               phase_q [NPORT];
    logic [FLIT_SIZE-1:0] cnt_q   [NPORT];

    hermes_rr_arbiter u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (state_q == ST_IDLE),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    assign route_out = xy_route(address_i,
                                flit_i[int'(sel_q)*FLIT_SIZE +: 16]);

    always_comb begin
        req_ack_o = '0;
        if (state_q == ST_GRANT) req_ack_o[sel_q] = 1'b1;
    end

    always_comb begin
        data_ack_o = '0;
        for (int p = 0; p < NPORT; p++) begin
            data_ack_o[p] = conn_valid_q[p] & data_av_i[p]
                          & credit_i[conn_q[p]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            out_q        <= EAST;
            conn_valid_q <= '0;
            out_busy_o   <= '0;
            in_sel_o     <= '0;
            for (int p = 0; p < NPORT; p++) begin
                conn_q[p]  <= '0;
                phase_q[p] <= PH_HEADER;
                cnt_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                if (data_ack_o[p]) begin
                    unique case (phase_q[p])
                        PH_HEADER: phase_q[p] <= PH_SIZE;
                        PH_SIZE: begin
                            phase_q[p] <= PH_PAYLOAD;
                            cnt_q[p]   <= flit_i[p*FLIT_SIZE +: FLIT_SIZE];
                        end
                        PH_PAYLOAD: begin
                            cnt_q[p] <= cnt_q[p] - FLIT_SIZE'(1);
                            // Last payload flit frees the output.
                            if (cnt_q[p] == FLIT_SIZE'(1)) begin
                                conn_valid_q[p]       <= 1'b0;
                                out_busy_o[conn_q[p]] <= 1'b0;
                                phase_q[p]            <= PH_HEADER;
                            end
                        end
                        default: phase_q[p] <= PH_HEADER;
                    endcase
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        sel_q   <= arb_grant;
                        state_q <= ST_ROUTE;
                    end
                end
                ST_ROUTE: begin
                    out_q   <= route_out;
                    state_q <= out_busy_o[route_out] ? ST_IDLE : ST_GRANT;
                end
                ST_GRANT: begin
                    out_busy_o[out_q]               <= 1'b1;
                    in_sel_o[3*int'(out_q) +: 3]    <= sel_q;
                    conn_q[sel_q]                   <= out_q;
                    conn_valid_q[sel_q]             <= 1'b1;
                    phase_q[sel_q]                  <= PH_HEADER;
                    state_q                         <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hermes_switch_control.sv
// Self-checking bench for hermes_switch_control: buffer model per input,
// packet scoreboard and XY/arbitration expectations.
module tb_hermes_switch_control;

    localparam int FS = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [15:0]     address_i;
    logic [4:0]      req_i;
    logic [5*FS-1:0] flit_i;
    logic [4:0]      data_av_i;
    logic [4:0]      credit_i;
    logic [4:0]      req_ack_o;
    logic [4:0]      data_ack_o;
    logic [14:0]     in_sel_o;
    logic [4:0]      out_busy_o;

    always #5 clk = ~clk;

    hermes_switch_control #(.FLIT_SIZE(FS)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .address_i  (address_i),
        .req_i      (req_i),
        .flit_i     (flit_i),
        .data_av_i  (data_av_i),
        .credit_i   (credit_i),
        .req_ack_o  (req_ack_o),
        .data_ack_o (data_ack_o),
        .in_sel_o   (in_sel_o),
        .out_busy_o (out_busy_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          req_m [5];
    bit          gnt_m [5];
    int          pos [5];
    int          tot [5];
    int          rt [5];
    int          size [5];
    logic [15:0] hdr [5];
    int          ack_cyc [5];
    int          ack_cnt [5];
    int          xfer [5];
    int          last_x [5];
    int          rel_cyc [5];
    int          rel_first [5];
    logic [4:0]  cred_m;
    logic [4:0]  prev_busy;
    bit          rnd_av;
    bit          rnd_cred;
    int          dmis, busy_mis, sel_mis, bad_ack;

    function automatic int xy(input logic [15:0] here, input logic [15:0] t);
        int dx;
        int dy;
        dx = int'(t[15:8]) - int'(here[15:8]);
        dy = int'(t[7:0]) - int'(here[7:0]);
        if (dx > 0) return 0;
        if (dx < 0) return 1;
        if (dy > 0) return 2;
        if (dy < 0) return 3;
        return 4;
    endfunction

    function automatic logic [FS-1:0] flit_at(input int p, input int k);
        if (k == 0) return {16'hA5A0 | 16'(p), hdr[p]};
        if (k == 1) return FS'(size[p]);
        return 32'hDA00_0000 + 32'(k);
    endfunction

    task automatic clear_model();
        for (int p = 0; p < 5; p++) begin
            req_m[p] = 0; gnt_m[p] = 0; pos[p] = 0; tot[p] = 0;
            rt[p] = 0; size[p] = 0; hdr[p] = '0;
            ack_cyc[p] = -1; ack_cnt[p] = 0; xfer[p] = 0; last_x[p] = -1;
            rel_cyc[p] = -1; rel_first[p] = -1;
        end
        prev_busy = '0;
        cred_m = '1;
        rnd_av = 0;
        rnd_cred = 0;
        dmis = 0; busy_mis = 0; sel_mis = 0; bad_ack = 0;
    endtask

    task automatic start_pkt(input int p, input logic [15:0] h, input int s);
        hdr[p] = h;
        size[p] = s;
        tot[p] = s + 2;
        pos[p] = 0;
        rt[p] = xy(address_i, h);
        req_m[p] = 1;
        gnt_m[p] = 0;
        ack_cyc[p] = -1;
        ack_cnt[p] = 0;
        xfer[p] = 0;
        last_x[p] = -1;
    endtask

    // One clock of the buffer model: drive at negedge, sample, commit at posedge.
    task automatic cycle();
        logic [4:0] eb, ra, da;
        bit exp_d;
        @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            req_i[p] = req_m[p];
            data_av_i[p] = (req_m[p] || gnt_m[p]) && pos[p] < tot[p]
                           && (!rnd_av || $urandom_range(0, 3) != 0);
            flit_i[p*FS +: FS] = flit_at(p, pos[p]);
        end
        credit_i = cred_m;
        #1;
        ra = req_ack_o;
        da = data_ack_o;
        eb = '0;
        for (int p = 0; p < 5; p++) begin
            if (gnt_m[p]) begin
                eb[rt[p]] = 1'b1;
                if (in_sel_o[rt[p]*3 +: 3] !== 3'(p)) sel_mis++;
            end
        end
        if (out_busy_o !== eb) busy_mis++;
        if ($countones(ra) > 1) bad_ack++;
        for (int p = 0; p < 5; p++) begin
            if (ra[p]) begin
                ack_cnt[p]++;
                ack_cyc[p] = cyc;
                if (!req_m[p] || eb[rt[p]]) bad_ack++;
            end
            exp_d = gnt_m[p] && pos[p] < tot[p] && data_av_i[p]
                    && credit_i[rt[p]];
            if (da[p] !== exp_d) dmis++;
            if (da[p] === 1'b1) begin
                xfer[p]++;
                last_x[p] = cyc;
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (prev_busy[o] && !out_busy_o[o]) begin
                rel_cyc[o] = cyc;
                if (rel_first[o] < 0) rel_first[o] = cyc;
            end
        end
        prev_busy = out_busy_o;
        @(posedge clk);
        for (int p = 0; p < 5; p++) begin
            if (ra[p]) begin
                req_m[p] = 0;
                gnt_m[p] = 1;
            end
            if (da[p] === 1'b1) begin
                pos[p]++;
                if (pos[p] >= tot[p]) gnt_m[p] = 0;
            end
        end
        cyc++;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n;
        bit pend;
        n = 0;
        ok = 0;
        while (n < budget) begin
            pend = 0;
            for (int p = 0; p < 5; p++)
                if (req_m[p] || gnt_m[p]) pend = 1;
            if (!pend) begin
                ok = 1;
                break;
            end
            if (rnd_cred) cred_m = 5'($urandom) | 5'($urandom);
            cycle();
            n++;
        end
        cred_m = '1;
        cycle();
    endtask

    task automatic wait_pos(input int p, input int k, output bit ok);
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            if (pos[p] >= k) begin
                ok = 1;
                break;
            end
            cycle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1;
        req_i = '0;
        data_av_i = '0;
        credit_i = '1;
        flit_i = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        req_i = '1;
        data_av_i = '1;
        credit_i = '1;
        @(negedge clk);
        #1;
        checks++;
        if (req_ack_o !== 5'b0) begin
            failures++;
            $display("FAIL reset_req_ack got=%b exp=0", req_ack_o);
        end
        checks++;
        if (data_ack_o !== 5'b0) begin
            failures++;
            $display("FAIL reset_data_ack got=%b exp=0", data_ack_o);
        end
        checks++;
        if (in_sel_o !== 15'b0) begin
            failures++;
            $display("FAIL reset_in_sel got=%h exp=0", in_sel_o);
        end
        checks++;
        if (out_busy_o !== 5'b0) begin
            failures++;
            $display("FAIL reset_out_busy got=%b exp=0", out_busy_o);
        end
        @(negedge clk);
        req_i = '0;
        rst_i = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_ack_o !== 5'b0 || out_busy_o !== 5'b0) begin
            failures++;
            $display("FAIL idle_no_conn got=%b/%b exp=0/0", data_ack_o, out_busy_o);
        end
    endtask

    task automatic test_grant_latency();
        int c0, s;
        bit ok;
        do_reset();
        address_i = 16'h0000;
        s = $urandom_range(1, 4);
        start_pkt(4, 16'h0201, s);
        c0 = cyc;
        repeat (3) cycle();
        #1;
        checks++;
        if (ack_cyc[4] !== c0 + 2) begin
            failures++;
            $display("FAIL grant_latency got=%0d exp=%0d", ack_cyc[4] - c0, 2);
        end
        checks++;
        if (out_busy_o !== 5'b00001) begin
            failures++;
            $display("FAIL grant_busy got=%b exp=00001", out_busy_o);
        end
        checks++;
        if (in_sel_o[2:0] !== 3'd4) begin
            failures++;
            $display("FAIL grant_in_sel got=%0d exp=4", in_sel_o[2:0]);
        end
        wait_done(200, ok);
        checks++;
        if (!ok || xfer[4] !== s + 2) begin
            failures++;
            $display("FAIL grant_xfers got=%0d exp=%0d done=%0d", xfer[4], s + 2, ok);
        end
        checks++;
        if (rel_cyc[0] !== last_x[4] + 1) begin
            failures++;
            $display("FAIL grant_release got=%0d exp=%0d", rel_cyc[0], last_x[4] + 1);
        end
        checks++;
        if (dmis + busy_mis + sel_mis + bad_ack !== 0) begin
            failures++;
            $display("FAIL grant_model got=%0d/%0d/%0d/%0d exp=0", dmis, busy_mis, sel_mis, bad_ack);
        end
    endtask

    task automatic test_route();
        logic [15:0] hs [3];
        int es [3];
        logic [15:0] h;
        int e, p;
        bit ok;
        hs = '{16'h0101, 16'h0100, 16'h0102};
        es = '{4, 3, 2};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 3) begin
                address_i = 16'h0101;
                h = hs[i];
                e = es[i];
            end else begin
                address_i = 16'($urandom);
                h = 16'($urandom);
                if (i == 6) h[15:8] = address_i[15:8];
                e = xy(address_i, h);
            end
            p = $urandom_range(0, 4);
            start_pkt(p, h, $urandom_range(1, 3));
            repeat (3) cycle();
            #1;
            checks++;
            if (out_busy_o !== 5'(1 << e) || in_sel_o[e*3 +: 3] !== 3'(p)) begin
                failures++;
                $display("FAIL route_%0d addr=%h hdr=%h got=%b/%0d exp=%b/%0d", i, address_i, h,
                         out_busy_o, in_sel_o[e*3 +: 3], 5'(1 << e), p);
            end
            wait_done(200, ok);
            checks++;
            if (!ok || dmis + busy_mis + sel_mis + bad_ack !== 0) begin
                failures++;
                $display("FAIL route_model_%0d got=%0d/%0d/%0d/%0d done=%0d exp=0", i,
                         dmis, busy_mis, sel_mis, bad_ack, ok);
            end
        end
    endtask

    task automatic test_credit();
        int x0;
        bit ok;
        do_reset();
        address_i = 16'h0000;
        start_pkt(4, 16'h0201, 3);
        wait_pos(4, 3, ok);
        cred_m[0] = 1'b0;
        x0 = xfer[4];
        repeat (2) cycle();
        checks++;
        if (!ok || xfer[4] !== x0 || out_busy_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL credit_hold got=%0d busy=%b exp=%0d busy=1", xfer[4], out_busy_o[0], x0);
        end
        cred_m[0] = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok || xfer[4] !== 5) begin
            failures++;
            $display("FAIL credit_xfers got=%0d exp=5", xfer[4]);
        end
        checks++;
        if (rel_cyc[0] !== last_x[4] + 1) begin
            failures++;
            $display("FAIL credit_release got=%0d exp=%0d", rel_cyc[0], last_x[4] + 1);
        end
        checks++;
        if (dmis + busy_mis + sel_mis + bad_ack !== 0) begin
            failures++;
            $display("FAIL credit_model got=%0d/%0d/%0d/%0d exp=0", dmis, busy_mis, sel_mis, bad_ack);
        end
    endtask

    task automatic test_contention();
        int c0, s1, s2;
        bit ok;
        do_reset();
        address_i = 16'h0101;
        s1 = $urandom_range(2, 5);
        s2 = $urandom_range(2, 5);
        start_pkt(1, 16'h0201, s1);
        start_pkt(2, 16'h0201, s2);
        c0 = cyc;
        wait_done(300, ok);
        checks++;
        if (ack_cyc[1] !== c0 + 2) begin
            failures++;
            $display("FAIL contention_first got=%0d exp=%0d", ack_cyc[1], c0 + 2);
        end
        checks++;
        if (ack_cyc[2] <= rel_first[0] || ack_cyc[2] > rel_first[0] + 3 || ack_cnt[2] !== 1) begin
            failures++;
            $display("FAIL contention_retry got=%0d cnt=%0d exp=(%0d,%0d] cnt=1",
                     ack_cyc[2], ack_cnt[2], rel_first[0], rel_first[0] + 3);
        end
        checks++;
        if (!ok || xfer[1] !== s1 + 2 || xfer[2] !== s2 + 2) begin
            failures++;
            $display("FAIL contention_xfers got=%0d/%0d exp=%0d/%0d", xfer[1], xfer[2], s1 + 2, s2 + 2);
        end
        checks++;
        if (dmis + busy_mis + sel_mis + bad_ack !== 0) begin
            failures++;
            $display("FAIL contention_model got=%0d/%0d/%0d/%0d exp=0", dmis, busy_mis, sel_mis, bad_ack);
        end
    endtask

    task automatic test_order();
        logic [15:0] tg [5];
        logic [15:0] tmp;
        int ord [5];
        int c0, j;
        bit ok;
`ifdef HERMES_RR_ARBITER_EN
        ord = '{0, 1, 2, 3, 4};
`else
        ord = '{4, 0, 1, 2, 3};
`endif
        tg = '{16'h0201, 16'h0001, 16'h0102, 16'h0100, 16'h0101};
        for (int i = 4; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = tg[i];
            tg[i] = tg[j];
            tg[j] = tmp;
        end
        do_reset();
        address_i = 16'h0101;
        for (int p = 0; p < 5; p++) start_pkt(p, tg[p], $urandom_range(1, 4));
        c0 = cyc;
        wait_done(300, ok);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ack_cyc[ord[k]] !== c0 + 2 + 3 * k) begin
                failures++;
                $display("FAIL order_%0d input=%0d got=%0d exp=%0d", k, ord[k],
                         ack_cyc[ord[k]] - c0, 2 + 3 * k);
            end
        end
        checks++;
        if (!ok || dmis + busy_mis + sel_mis + bad_ack !== 0) begin
            failures++;
            $display("FAIL order_model got=%0d/%0d/%0d/%0d done=%0d exp=0", dmis, busy_mis,
                     sel_mis, bad_ack, ok);
        end
    endtask

    task automatic test_reset_mid();
        int c0, s;
        bit ok;
        do_reset();
        address_i = 16'h0000;
        start_pkt(4, 16'h0201, 6);
        wait_pos(4, 4, ok);
        @(negedge clk);
        rst_i = 1;
        #1;
        checks++;
        if (!ok || out_busy_o !== 5'b0 || data_ack_o !== 5'b0) begin
            failures++;
            $display("FAIL midrst_busy got=%b/%b exp=0/0", out_busy_o, data_ack_o);
        end
        checks++;
        if (in_sel_o !== 15'b0 || req_ack_o !== 5'b0) begin
            failures++;
            $display("FAIL midrst_sel got=%h/%b exp=0/0", in_sel_o, req_ack_o);
        end
        @(negedge clk);
        req_i = '0;
        data_av_i = '0;
        rst_i = 0;
        clear_model();
        s = $urandom_range(1, 4);
        start_pkt(1, 16'h0000, s);
        c0 = cyc;
        wait_done(200, ok);
        checks++;
        if (ack_cyc[1] !== c0 + 2 || !ok || xfer[1] !== s + 2) begin
            failures++;
            $display("FAIL midrst_regrant got=%0d/%0d exp=%0d/%0d", ack_cyc[1] - c0, xfer[1], 2, s + 2);
        end
        checks++;
        if (dmis + busy_mis + sel_mis + bad_ack !== 0) begin
            failures++;
            $display("FAIL midrst_model got=%0d/%0d/%0d/%0d exp=0", dmis, busy_mis, sel_mis, bad_ack);
        end
    endtask

    task automatic test_random();
        bit started [5];
        logic [7:0] tx, ty;
        bit ok;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            address_i = 16'($urandom);
            dmis = 0; busy_mis = 0; sel_mis = 0; bad_ack = 0;
            for (int p = 0; p < 5; p++) begin
                started[p] = (p == r) || ($urandom_range(0, 1) == 1);
                if (started[p]) begin
                    tx = address_i[15:8] + 8'($urandom_range(0, 2)) - 8'd1;
                    ty = address_i[7:0] + 8'($urandom_range(0, 2)) - 8'd1;
                    start_pkt(p, {tx, ty}, $urandom_range(1, 5));
                end
            end
            rnd_av = 1;
            rnd_cred = 1;
            wait_done(800, ok);
            rnd_av = 0;
            rnd_cred = 0;
            checks++;
            if (!ok || dmis + busy_mis + sel_mis + bad_ack !== 0) begin
                failures++;
                $display("FAIL random_%0d_model got=%0d/%0d/%0d/%0d done=%0d exp=0", r,
                         dmis, busy_mis, sel_mis, bad_ack, ok);
            end
            for (int p = 0; p < 5; p++) begin
                if (started[p]) begin
                    checks++;
                    if (ack_cnt[p] !== 1 || xfer[p] !== tot[p]) begin
                        failures++;
                        $display("FAIL random_%0d_in%0d got=%0d/%0d exp=1/%0d", r, p,
                                 ack_cnt[p], xfer[p], tot[p]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_i = 1;
        address_i = '0;
        req_i = '0;
        data_av_i = '0;
        credit_i = '1;
        flit_i = '0;
        clear_model();
        test_reset();
        test_grant_latency();
        test_route();
        test_credit();
        test_contention();
        test_order();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
